// File: rtl/instr_ram_loader.sv
// Writable instruction RAM with a valid/ready byte loader that holds the core in reset until a program is in place.
// Optional build macro LOADER_CHECKSUM_EN: the final beat is a checksum byte that must bring the byte sum to zero.
module instr_ram_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  input_Clock,
    input  logic                  input_Reset,
    input  logic                  input_Load_Start,
    input  logic                  input_Run,
    input  logic                  input_Load_Valid,
    input  logic [DATA_WIDTH-1:0] input_Load_Data,
    input  logic                  input_Load_Last,
    output logic                  output_Load_Ready,
    input  logic [ADDR_WIDTH-1:0] input_Address,
    output logic [DATA_WIDTH-1:0] output_Instruction,
    output logic                  output_Core_Reset,
    output logic [ADDR_WIDTH:0]   output_Load_Count,
    output logic                  output_Error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      ptr_q;
    logic [CNT_W-1:0]      ptr_d;
    logic                  ready_q;
    logic                  core_rst_q;
    logic                  error_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic beat;
    logic wr_en;
    logic load_enter;

    // Load_Start only restarts a load from outside LOAD; inside LOAD it is ignored.
    assign load_enter = input_Load_Start && (state_q != LOAD);
    assign beat       = (state_q == LOAD) && ready_q && input_Load_Valid;
    assign ptr_d      = ptr_q + 1'b1;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
    logic [DATA_WIDTH-1:0] sum_d;

    assign sum_d = sum_q + input_Load_Data;
    // The checksum beat is never stored, and a data beat past the end is dropped.
    assign wr_en = beat && !input_Load_Last && (ptr_q < DEPTH_C);
`else
    assign wr_en = beat;
`endif

    always_ff @(posedge input_Clock or posedge input_Reset) begin
        if (input_Reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ready_q    <= 1'b0;
            core_rst_q <= 1'b1;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else if (load_enter) begin
            state_q    <= LOAD;
            ptr_q      <= '0;
            ready_q    <= 1'b1;
            core_rst_q <= 1'b1;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (input_Run) begin
                        state_q    <= RUN;
                        core_rst_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (beat) begin
`ifdef LOADER_CHECKSUM_EN
                        if (input_Load_Last) begin
                            ready_q <= 1'b0;
                            if (sum_d == '0) begin
                                state_q    <= RUN;
                                core_rst_q <= 1'b0;
                            end else begin
                                state_q <= ERROR;
                                error_q <= 1'b1;
                            end
                        end else if (ptr_q == DEPTH_C) begin
                            state_q <= ERROR;
                            ready_q <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            ptr_q <= ptr_d;
                            sum_q <= sum_d;
                        end
`else
                        ptr_q <= ptr_d;
                        if (input_Load_Last) begin
                            state_q    <= RUN;
                            ready_q    <= 1'b0;
                            core_rst_q <= 1'b0;
                        end else if (ptr_q == LAST_C) begin
                            state_q <= ERROR;
                            ready_q <= 1'b0;
                            error_q <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    ready_q    <= 1'b0;
                    core_rst_q <= 1'b0;
                end
                default: begin
                    ready_q    <= 1'b0;
                    core_rst_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so a program survives a reset.
    always_ff @(posedge input_Clock) begin
        if (wr_en) begin
            mem[ptr_q[IDX_W-1:0]] <= input_Load_Data;
        end
    end

    assign output_Instruction = ({1'b0, input_Address} < DEPTH_C) ? mem[input_Address[IDX_W-1:0]] : '0;
    assign output_Load_Ready  = ready_q;
    assign output_Core_Reset  = core_rst_q;
    assign output_Load_Count  = ptr_q;
    assign output_Error       = error_q;

endmodule
